// File: rtl/mlp_pow2_pkg.sv
// Shared definitions for the sequential power-of-two-weight MLP classifier:
// weight-code field layout, FSM states and the shift/add term decoder.
package mlp_pow2_pkg;

  localparam int WCODE_W  = 5;
  localparam int WEN_BIT  = 4;
  localparam int WNEG_BIT = 3;
  localparam int WK_LSB   = 0;
  localparam int WK_W     = 3;

  // Operands wider than OPND_W are not supported; TERM_W leaves room for a 2^7 shift.
  localparam int OPND_W = 32;
  localparam int TERM_W = 40;

  typedef logic [WCODE_W-1:0] wcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_L0,
    ST_L1,
    ST_DONE
  } state_t;

  function automatic logic signed [TERM_W-1:0] pow2_term(input wcode_t code,
                                                         input logic [OPND_W-1:0] operand);
    logic [TERM_W-1:0] mag;
    mag = {{(TERM_W-OPND_W){1'b0}}, operand} << code[WK_LSB +: WK_W];
    if (!code[WEN_BIT]) return '0;
    return code[WNEG_BIT] ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/mlp_pow2_mac.sv
// Single shift/add/sub accumulator shared by both layers, with bias load on the
// first term and a QReLU (hidden) or ReLU (output) view of the running sum.
module mlp_pow2_mac
  import mlp_pow2_pkg::*;
#(
  parameter int OP_W  = 8,
  parameter int ACC_W = 18,
  parameter int HID_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [OP_W-1:0]  operand,
  input  wcode_t           code,
  input  logic [ACC_W-1:0] bias,
  input  logic             qrelu_sel,
  output logic [ACC_W-1:0] act
);

  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         base;
  logic [ACC_W:0]           sum_ext;
  logic signed [TERM_W-1:0] term;
  logic                     term_fits;
  logic                     sum_ovf;

  assign term      = pow2_term(code, OPND_W'(operand));
  assign base      = load ? bias : acc;
  assign sum_ext   = {base[ACC_W-1], base} + {term[ACC_W-1], term[ACC_W-1:0]};
  assign sum_ovf   = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
  assign term_fits = (term[TERM_W-1:ACC_W-1] == '0) || (&term[TERM_W-1:ACC_W-1]);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_ext[ACC_W-1:0];
    end
  end

  // NOTE: act gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    act = acc;
    if (acc[ACC_W-1]) begin
      act = '0;
    end else if (qrelu_sel && (|acc[ACC_W-2:HID_W])) begin
      act = ACC_W'({HID_W{1'b1}});
    end else if (qrelu_sel) begin
      act = ACC_W'(acc[HID_W-1:0]);
    end
  end

  // The integrator sizes ACC_W so the wrapping sum never actually wraps.
  assert property (@(posedge clk) disable iff (!rst_n) en |-> (term_fits && !sum_ovf));

endmodule

// File: rtl/mlp_pow2_seq_classifier.sv
// Sequential 2-layer power-of-two MLP classifier: one MAC term per cycle,
// folded argmax over an optionally masked score, valid/ready on both sides.
module mlp_pow2_seq_classifier
  import mlp_pow2_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int IN_W  = 4,
  parameter int N_HID = 3,
  parameter int N_OUT = 3,
  parameter int HID_W = 8,
  parameter int ACC_W = 18,
  parameter logic [N_HID*N_IN*WCODE_W-1:0]  W0 = '0,
  parameter logic [N_HID*ACC_W-1:0]         B0 = '0,
  parameter logic [N_OUT*N_HID*WCODE_W-1:0] W1 = '0,
  parameter logic [N_OUT*ACC_W-1:0]         B1 = '0,
  parameter logic [ACC_W-1:0]               ARGMAX_MASK = '1,
  parameter int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] inp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out,
  output logic [ACC_W-1:0]     out_score,
  output logic                 busy
);

  localparam int OP_W  = (IN_W > HID_W) ? IN_W : HID_W;
  localparam int MAXN0 = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int MAXN  = (MAXN0 > N_OUT) ? MAXN0 : N_OUT;
  localparam int CNT_W = $clog2(MAXN + 1);

  state_t               state;
  logic [CNT_W-1:0]     term_idx;
  logic [CNT_W-1:0]     unit_idx;
  logic [N_IN*IN_W-1:0] x_reg;
  logic [HID_W-1:0]     h_reg [N_HID];
  logic [IDX_W-1:0]     best_idx;
  logic [ACC_W-1:0]     best_score;

  logic [OP_W-1:0]  operand;
  wcode_t           code;
  logic [ACC_W-1:0] bias;
  logic [ACC_W-1:0] mac_act;
  logic             mac_en;
  logic             take_new;
  logic [IDX_W-1:0] new_idx;
  logic [ACC_W-1:0] new_score;

  // Operand/weight/bias mux: neuron (or class) unit_idx, term term_idx.
  always_comb begin
    operand = '0;
    code    = '0;
    bias    = '0;
    if (state == ST_L0) begin
      for (int i = 0; i < N_IN; i++)
        if (term_idx == CNT_W'(i)) operand = OP_W'(x_reg[i*IN_W +: IN_W]);
      for (int h = 0; h < N_HID; h++) begin
        if (unit_idx == CNT_W'(h)) bias = B0[h*ACC_W +: ACC_W];
        for (int i = 0; i < N_IN; i++)
          if (unit_idx == CNT_W'(h) && term_idx == CNT_W'(i))
            code = W0[(h*N_IN+i)*WCODE_W +: WCODE_W];
      end
    end else if (state == ST_L1) begin
      for (int h = 0; h < N_HID; h++)
        if (term_idx == CNT_W'(h)) operand = OP_W'(h_reg[h]);
      for (int c = 0; c < N_OUT; c++) begin
        if (unit_idx == CNT_W'(c)) bias = B1[c*ACC_W +: ACC_W];
        for (int h = 0; h < N_HID; h++)
          if (unit_idx == CNT_W'(c) && term_idx == CNT_W'(h))
            code = W1[(c*N_HID+h)*WCODE_W +: WCODE_W];
      end
    end
  end

  assign mac_en = ((state == ST_L0) && (term_idx != CNT_W'(N_IN))) ||
                  ((state == ST_L1) && (term_idx != CNT_W'(N_HID)));

  mlp_pow2_mac #(
    .OP_W (OP_W),
    .ACC_W(ACC_W),
    .HID_W(HID_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mac_en),
    .load     (term_idx == '0),
    .operand  (operand),
    .code     (code),
    .bias     (bias),
    .qrelu_sel(state == ST_L0),
    .act      (mac_act)
  );

  // Strict compare keeps the lower class index on (masked) ties.
  assign take_new  = (unit_idx == '0) ||
                     ((mac_act & ARGMAX_MASK) > (best_score & ARGMAX_MASK));
  assign new_idx   = take_new ? IDX_W'(unit_idx) : best_idx;
  assign new_score = take_new ? mac_act : best_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      term_idx   <= '0;
      unit_idx   <= '0;
      x_reg      <= '0;
      best_idx   <= '0;
      best_score <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out        <= '0;
      out_score  <= '0;
      busy       <= 1'b0;
      // NOTE: the hidden register array is tiny and must read as zero after reset, so it is reset per entry.
      for (int h = 0; h < N_HID; h++) h_reg[h] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x_reg    <= inp;
            term_idx <= '0;
            unit_idx <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_L0;
          end
        end
        ST_L0: begin
          if (term_idx == CNT_W'(N_IN)) begin
            for (int h = 0; h < N_HID; h++)
              if (unit_idx == CNT_W'(h)) h_reg[h] <= mac_act[HID_W-1:0];
            term_idx <= '0;
            if (unit_idx == CNT_W'(N_HID - 1)) begin
              unit_idx <= '0;
              state    <= ST_L1;
            end else begin
              unit_idx <= unit_idx + CNT_W'(1);
            end
          end else begin
            term_idx <= term_idx + CNT_W'(1);
          end
        end
        ST_L1: begin
          if (term_idx == CNT_W'(N_HID)) begin
            best_idx   <= new_idx;
            best_score <= new_score;
            term_idx   <= '0;
            if (unit_idx == CNT_W'(N_OUT - 1)) begin
              unit_idx  <= '0;
              out       <= new_idx;
              out_score <= new_score;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              unit_idx <= unit_idx + CNT_W'(1);
            end
          end else begin
            term_idx <= term_idx + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_pow2_seq_classifier.sv
// Scoreboard bench: two lockstep instances (full mask and bit-9-only mask)
// checked against an arithmetic reference model of the classifier.
module tb_mlp_pow2_seq_classifier;

  localparam int N_IN  = 4;
  localparam int IN_W  = 4;
  localparam int N_HID = 3;
  localparam int N_OUT = 3;
  localparam int HID_W = 8;
  localparam int ACC_W = 18;
  localparam int IDX_W = 2;
  localparam int LAT   = N_HID*(N_IN+1) + N_OUT*(N_HID+1);

  // Codes: 5'b10kkk = +2^k, 5'b11kkk = -2^k, 0 = no connection. Highest index first.
  localparam logic [N_HID*N_IN*5-1:0] W0_CFG = {
    5'b10010, 5'b10011, 5'b00000, 5'b00000,   // h2: x3 +4, x2 +8
    5'b11000, 5'b10001, 5'b10010, 5'b00000,   // h1: x3 -1, x2 +2, x1 +4
    5'b00000, 5'b00000, 5'b00000, 5'b10111};  // h0: x0 +128
  localparam logic [N_HID*ACC_W-1:0] B0_CFG = {18'd0, 18'h3FFFD, 18'd0};
  localparam logic [N_OUT*N_HID*5-1:0] W1_CFG = {
    5'b11010, 5'b00000, 5'b10001,             // c2: h2 -4, h0 +2
    5'b10000, 5'b10010, 5'b00000,             // c1: h2 +1, h1 +4
    5'b00000, 5'b10001, 5'b10000};            // c0: h1 +2, h0 +1
  localparam logic [N_OUT*ACC_W-1:0] B1_CFG = {18'd0, 18'd12, 18'h3FF9C};
  localparam logic [ACC_W-1:0] MASK_A = '1;
  localparam logic [ACC_W-1:0] MASK_B = 18'h00200;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic [N_IN*IN_W-1:0] inp = '0;
  logic                 in_ready_a, out_valid_a, busy_a;
  logic                 in_ready_b, out_valid_b, busy_b;
  logic [IDX_W-1:0]     out_a, out_b;
  logic [ACC_W-1:0]     score_a, score_b;

  typedef struct {
    int cls_a;
    int score_a;
    int cls_b;
    int score_b;
    int accept_cycle;
    int hold;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycle = 0;
  bit   finished = 1'b0;

  mlp_pow2_seq_classifier #(
    .N_IN(N_IN), .IN_W(IN_W), .N_HID(N_HID), .N_OUT(N_OUT), .HID_W(HID_W), .ACC_W(ACC_W),
    .W0(W0_CFG), .B0(B0_CFG), .W1(W1_CFG), .B1(B1_CFG), .ARGMAX_MASK(MASK_A), .IDX_W(IDX_W)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .inp(inp),
    .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a), .out_score(score_a),
    .busy(busy_a)
  );

  mlp_pow2_seq_classifier #(
    .N_IN(N_IN), .IN_W(IN_W), .N_HID(N_HID), .N_OUT(N_OUT), .HID_W(HID_W), .ACC_W(ACC_W),
    .W0(W0_CFG), .B0(B0_CFG), .W1(W1_CFG), .B1(B1_CFG), .ARGMAX_MASK(MASK_B), .IDX_W(IDX_W)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .inp(inp),
    .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b), .out_score(score_b),
    .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic int wval(input logic [4:0] code);
    if (!code[4]) return 0;
    return code[3] ? -(1 << code[2:0]) : (1 << code[2:0]);
  endfunction

  // Reference: integer dot products, clamp, then first-maximum over masked scores.
  function automatic void model(input logic [N_IN*IN_W-1:0] x, input logic [ACC_W-1:0] mask,
                                output int cls, output int score);
    int hid[N_HID];
    int acc;
    int s;
    for (int h = 0; h < N_HID; h++) begin
      acc = int'($signed(B0_CFG[h*ACC_W +: ACC_W]));
      for (int i = 0; i < N_IN; i++)
        acc += wval(W0_CFG[(h*N_IN+i)*5 +: 5]) * int'(x[i*IN_W +: IN_W]);
      hid[h] = (acc < 0) ? 0 : ((acc > (1 << HID_W) - 1) ? (1 << HID_W) - 1 : acc);
    end
    cls = 0;
    score = 0;
    for (int c = 0; c < N_OUT; c++) begin
      acc = int'($signed(B1_CFG[c*ACC_W +: ACC_W]));
      for (int h = 0; h < N_HID; h++)
        acc += wval(W1_CFG[(c*N_HID+h)*5 +: 5]) * hid[h];
      s = (acc < 0) ? 0 : acc;
      if (c == 0 || (s & int'(mask)) > (score & int'(mask))) begin
        cls = c;
        score = s;
      end
    end
  endfunction

  task automatic send(input logic [N_IN*IN_W-1:0] x, input bit expect_result, input int hold,
                      output int acc_cycle);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    inp = x;
    in_valid = 1'b1;
    while (!in_ready_a && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_a) begin
      check("accept_timeout", in_ready_a, 1);
      in_valid = 1'b0;
      acc_cycle = -1;
      return;
    end
    acc_cycle = cycle + 1;
    if (expect_result) begin
      model(x, MASK_A, e.cls_a, e.score_a);
      model(x, MASK_B, e.cls_b, e.score_b);
      e.accept_cycle = acc_cycle;
      e.hold = hold;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("busy_during_run", busy_a, 1);
      check("in_ready_during_run", in_ready_a, 0);
      inp = (N_IN*IN_W)'($urandom);
      in_valid = k[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per presented result, then holds out_ready low for e.hold cycles.
  initial begin : monitor
    exp_t e;
    bit   active = 1'b0;
    bit   have = 1'b0;
    int   hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        out_ready = 1'b0;
      end else if (out_valid_a && !active) begin
        active = 1'b1;
        check("valid_lockstep_b", out_valid_b, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_valid_a, 0);
          have = 1'b0;
          hold = 0;
        end else begin
          e = exp_q.pop_front();
          have = 1'b1;
          hold = e.hold;
          check("latency", cycle - e.accept_cycle, LAT);
          check("class_full_mask", out_a, e.cls_a);
          check("score_full_mask", score_a, e.score_a);
          check("class_bit9_mask", out_b, e.cls_b);
          check("score_bit9_mask", score_b, e.score_b);
        end
        out_ready = (hold == 0);
      end else if (active) begin
        if (out_ready) begin
          check("valid_drop_a", out_valid_a, 0);
          check("valid_drop_b", out_valid_b, 0);
          active = 1'b0;
          out_ready = 1'b0;
        end else begin
          check("hold_valid", out_valid_a, 1);
          check("hold_in_ready", in_ready_a, 0);
          if (have) begin
            check("hold_class", out_a, e.cls_a);
            check("hold_score", score_a, e.score_a);
            check("hold_class_b", out_b, e.cls_b);
          end
          hold--;
          out_ready = (hold <= 0);
        end
      end
    end
  end

  initial begin : stim
    int ac;
    bit saw;
    int w;
    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready_a, 0);
    check("reset_out_valid", out_valid_a, 0);
    check("reset_out", out_a, 0);
    check("reset_out_score", score_a, 0);
    check("reset_busy", busy_a, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready_a, 1);
    check("post_reset_busy", busy_a, 0);

    send(16'h0005, 1'b1, 10, ac);   // h0 saturates: scores 155/12/510
    send(16'h0000, 1'b1, 3, ac);    // hidden bias clipped, only c1 bias survives
    send(16'h000F, 1'b1, 0, ac);    // saturation, c0 bias -100
    send(16'h10F1, 1'b1, 5, ac);    // c1 == c2 == 240 tie
    for (int n = 0; n < 30; n++)
      send((N_IN*IN_W)'($urandom), 1'b1, int'($urandom_range(0, 6)), ac);

    send((N_IN*IN_W)'($urandom), 1'b0, 0, ac);
    if (ac >= 0) begin
      while (cycle < ac + N_HID*(N_IN+1) + 3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy_a, 0);
      check("abort_out_valid", out_valid_a, 0);
      check("abort_out", out_a, 0);
      check("abort_out_score", score_a, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (LAT + 10) begin
        @(negedge clk);
        if (out_valid_a || out_valid_b) saw = 1'b1;
      end
      check("no_result_after_abort", saw, 0);
      check("in_ready_after_abort", in_ready_a, 1);
    end

    send((N_IN*IN_W)'($urandom), 1'b1, 2, ac);
    w = 0;
    while ((exp_q.size() != 0 || out_valid_a) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue", exp_q.size(), 0);
    finished = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    check("watchdog_finished", finished, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
